io_ram_loader: RTL and testbench
================================

# io_ram_loader

Upstream write-port controller for the data RAM. It owns the RAM's `WE`/`A`/`WD` inputs. When idle it passes CPU store traffic straight through. On `start` it takes the port, accepts an 8-bit byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes `num_words` words to consecutive word addresses from `BASE_ADDR`. It then pulses `done` and hands the port back to the CPU.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h0000_0000`: byte address of the first word written; must be word-aligned.
- `MAX_WORDS`, default `102`: RAM depth in words; upper bound for `num_words`.
- `CNT_W`, default `8`: width of `num_words` and the word counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a load; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of a load in progress.
- `num_words`, in, `CNT_W`: number of words to load; sampled with `start`.
- `byte_in`, in, 8: stream data.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: loader can accept a byte.
- `cpu_we`, in, 1: CPU write enable.
- `cpu_a`, in, 32: CPU address.
- `cpu_wd`, in, 32: CPU write data.
- `ram_we`, out, 1: to RAM `WE`.
- `ram_a`, out, 32: to RAM `A`.
- `ram_wd`, out, 32: to RAM `WD`.
- `busy`, out, 1: loader owns the RAM port; CPU must stall.
- `done`, out, 1: one-cycle pulse after the final word is written.
- `err`, out, 1: one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- **IDLE**
  - `ram_we`/`ram_a`/`ram_wd` = `cpu_we`/`cpu_a`/`cpu_wd`, combinational pass-through.
  - `busy`=0, `byte_ready`=0.
  - `start`=1 with 1 ≤ `num_words` ≤ `MAX_WORDS`: latch `num_words`, clear word index and byte count, go to COLLECT.
  - `start`=1 with `num_words`=0 or > `MAX_WORDS`: pulse `err` next cycle, stay IDLE.
- **COLLECT**
  - `byte_ready`=1, `busy`=1, `ram_we`=0.
  - Each handshake (`byte_valid`&&`byte_ready` at posedge) stores `byte_in` in lane `byte_cnt`; byte 0 goes to bits [7:0], byte 3 to [31:24].
  - On the 4th accepted byte, go to WRITE.
- **WRITE**
  - `ram_we`=1 for exactly one cycle, `byte_ready`=0.
  - `ram_a` = `BASE_ADDR` + 4×`word_idx` (32-bit unsigned; wrap ignored, bounded by `MAX_WORDS`).
  - `ram_wd` = the packed word.
  - `word_idx` increments.
  - Next state: DONE if `word_idx` = `num_words`−1, else COLLECT.
- **DONE**
  - `done`=1 for one cycle, `busy`=1, `ram_we`=0; then IDLE.
- While `busy`=1, `cpu_we` is ignored (not queued). The CPU stalls on `busy`.
- `start` outside IDLE is ignored.
- `abort`=1 in COLLECT or WRITE:
  - Go to IDLE next cycle; the partial word is discarded.
  - No `done`, no `err`.
  - `abort` in the same cycle as WRITE suppresses that write (`ram_we`=0).
- `abort` in IDLE or DONE has no effect.
- `byte_valid` while `byte_ready`=0 is not consumed; the source holds the byte.

## Timing
- Reset values:
  - State IDLE.
  - `word_idx`, `byte_cnt`, packed word, latched count = 0.
  - `byte_ready`=0, `busy`=0, `done`=0, `err`=0.
  - `ram_we` follows `cpu_we`.
- Reset asserted mid-load: immediate return to IDLE; partial word lost; no RAM write occurs after reset asserts.
- `start` sampled at edge T; COLLECT from T+1. The first byte can be accepted at edge T+1.
- Minimum per word: 4 accept cycles + 1 write cycle = 5 cycles. A full-rate load of N words asserts `done` in cycle T+1+5N.
- `busy` rises in the cycle after `start` is sampled and falls when DONE exits.
- `err` is asserted in the cycle after the rejected `start`.
- The RAM captures `WD` at the posedge ending the WRITE cycle, so the word is readable from the following cycle.

## Structure
- Package `io_loader_pkg`:
  - `loader_state_t` enum (IDLE, COLLECT, WRITE, DONE).
  - `BYTES_PER_WORD`=4.
  - `WORD_W`=32.
- Sub-module `byte_packer`:
  - 2-bit lane counter plus 32-bit lane register.
  - Inputs: `clk`, `rst`, `clr`, `push`, `byte_in`.
  - Outputs: `word`, `full` (4th byte accepted).
- Top level holds the FSM, word index, address generation and the CPU/loader port mux.

## Test plan
- Reset then idle pass-through:
  - `cpu_we`=1, `cpu_a`=0x8, `cpu_wd`=0xDEADBEEF → `ram_we`=1, `ram_a`=0x8, `ram_wd`=0xDEADBEEF the same cycle.
  - `busy`=0.
- 2-word load, full-rate bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88:
  - Writes 0x44332211 @0x0 and 0x88776655 @0x4.
  - `done` in cycle T+11.
- Back-pressure: `byte_valid` toggling 1/0:
  - Same data is written as with full-rate bytes.
  - No byte lost or duplicated.
  - `byte_ready`=0 during WRITE.
- Rejected starts:
  - `num_words`=0 → `err` one cycle, `busy` stays 0.
  - `num_words`=103 → same.
- `abort` after 2 bytes of word 1 of a 3-word load:
  - Only word 0 written; IDLE next cycle; no `done`.
  - A new `start` succeeds.
- Async `rst` pulsed mid-COLLECT, and `cpu_we`=1 during `busy`:
  - No RAM write from either.
  - All outputs return to reset values immediately.

Source files
------------

// File: rtl/io_loader_pkg.sv
// Shared types and constants for the data-RAM loader.
package io_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words: the first byte of a
// word lands in bits [7:0], the fourth in bits [31:24].
module byte_packer
  import io_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0]        lane;
  logic [WORD_W-1:0] word_q;

  // Lane counter and lane register; clr drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane   <= '0;
      word_q <= '0;
    end else if (clr) begin
      lane   <= '0;
      word_q <= '0;
    end else if (push) begin
      word_q[{lane, 3'b000} +: 8] <= byte_in;
      lane                        <= lane + 2'd1;
    end
  end

  assign word = word_q;
  // Asserted in the cycle whose handshake delivers the last byte of a word.
  assign full = push && !clr && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/io_ram_loader.sv
// Data-RAM write-port controller: passes CPU stores through when idle, and on
// start takes the port to load a byte stream as consecutive 32-bit words.
module io_ram_loader
  import io_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 102,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_words,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_a,
  input  logic [31:0]      cpu_wd,
  output logic             ram_we,
  output logic [31:0]      ram_a,
  output logic [31:0]      ram_wd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  loader_state_t     state, state_nxt;
  logic [CNT_W-1:0]  word_idx;
  logic [CNT_W-1:0]  num_lat;
  logic              err_q;
  logic              start_ok;
  logic              start_bad;
  logic              last_word;
  logic              push;
  logic              clr;
  logic              full;
  logic [WORD_W-1:0] packed_word;

  assign start_ok  = start && (num_words != '0) && (32'(num_words) <= 32'(MAX_WORDS));
  assign start_bad = start && !start_ok;
  assign last_word = (word_idx == (num_lat - CNT_W'(1)));

  assign byte_ready = (state == COLLECT);
  // A byte arriving alongside abort is part of the discarded word.
  assign push       = byte_valid && byte_ready && !abort;
  assign clr        = (state == IDLE) || abort;

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .byte_in (byte_in),
    .word    (packed_word),
    .full    (full)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word index, latched word count and the rejected-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
      num_lat  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_bad;
      if ((state == IDLE) && start_ok) begin
        word_idx <= '0;
        num_lat  <= num_words;
      end else if ((state == WRITE) && !abort) begin
        word_idx <= word_idx + CNT_W'(1);
      end
    end
  end

  // Next state and the CPU/loader RAM port mux.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    ram_we    = 1'b0;
    ram_a     = '0;
    ram_wd    = '0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        ram_we = cpu_we;
        ram_a  = cpu_a;
        ram_wd = cpu_wd;
        if (start_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (abort)     state_nxt = IDLE;
        else if (full) state_nxt = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          ram_we    = 1'b1;
          ram_a     = BASE_ADDR + (32'(word_idx) << 2);
          ram_wd    = packed_word;
          state_nxt = last_word ? DONE : COLLECT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign done = (state == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_io_ram_loader.sv
// Bench for io_ram_loader: random byte streams checked against a word-packing
// model and a log of the loader's RAM writes.
module tb_io_ram_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, byte_valid, byte_ready;
  logic [7:0]  num_words, byte_in;
  logic        cpu_we, ram_we, busy, done, err;
  logic [31:0] cpu_a, cpu_wd, ram_a, ram_wd;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt;
  int          ready_viol;
  logic [7:0]  stim[$];

  io_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Log every RAM write issued while the loader owns the port.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we && busy) begin
        wr_a.push_back(ram_a);
        wr_d.push_back(ram_wd);
        if (byte_ready) ready_viol++;
      end
      if (done) done_cnt++;
    end
  end

  // Reference: word k is bytes 4k..4k+3 of the stream, first byte least significant.
  function automatic logic [31:0] model_word(input int k);
    return 32'(stim[4*k]) + (32'(stim[4*k+1]) << 8) +
           (32'(stim[4*k+2]) << 16) + (32'(stim[4*k+3]) << 24);
  endfunction

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    done_cnt   = 0;
    ready_viol = 0;
  endtask

  task automatic fill_stim(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  // Start a load of n words and stream stim; mode 0 full rate, 1 toggling, 2 random.
  // done_cyc is the cycle (1 = first cycle after the start edge) where done is seen.
  task automatic do_load(input int n, input int mode, output int done_cyc);
    int idx = 0;
    int k;
    logic v;
    done_cyc = -1;
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'(n);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 600) begin
      if (done) begin
        done_cyc = k;
        break;
      end
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = ((k % 2) == 1);
      else                v = 1'($urandom_range(0, 1));
      byte_valid = v && (idx < stim.size());
      byte_in    = (idx < stim.size()) ? stim[idx] : 8'h00;
      if (byte_valid && byte_ready) idx++;
      @(negedge clk);
      k++;
    end
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({busy, byte_ready, done, err, ram_we} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy/ready/done/err/we=%b required 00000",
               {busy, byte_ready, done, err, ram_we});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, byte_ready, done, err, ram_we} !== 5'b0) begin
      fails++;
      $display("FAIL post_reset_idle: busy/ready/done/err/we=%b required 00000",
               {busy, byte_ready, done, err, ram_we});
    end
    cpu_we = 1'b1;
    cpu_a  = 32'h8;
    cpu_wd = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if ({ram_we, ram_a, ram_wd, busy} !== {1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0}) begin
      fails++;
      $display("FAIL passthru_fixed: we=%b a=%h wd=%h busy=%b required 1 00000008 deadbeef 0",
               ram_we, ram_a, ram_wd, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_a  = $urandom;
      cpu_wd = $urandom;
      #1;
      tests_run++;
      if ({ram_we, ram_a, ram_wd} !== {cpu_we, cpu_a, cpu_wd}) begin
        fails++;
        $display("FAIL passthru_rand: we=%b a=%h wd=%h required %b %h %h",
                 ram_we, ram_a, ram_wd, cpu_we, cpu_a, cpu_wd);
      end
    end
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic test_two_word();
    int dc;
    stim.delete();
    for (int i = 1; i <= 8; i++) stim.push_back(8'(i * 8'h11));
    clear_log();
    do_load(2, 0, dc);
    tests_run++;
    if (dc !== 11) begin
      fails++;
      $display("FAIL two_word_done_cycle: got %0d required 11", dc);
    end
    tests_run++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL two_word_release: done/busy=%b required 00", {done, busy});
    end
    tests_run++;
    if (wr_a.size() !== 2 || done_cnt !== 1) begin
      fails++;
      $display("FAIL two_word_counts: writes=%0d dones=%0d required 2 1", wr_a.size(), done_cnt);
    end
    for (int k = 0; k < 2 && k < wr_a.size(); k++) begin
      tests_run++;
      if (wr_a[k] !== 32'(4 * k) || wr_d[k] !== model_word(k)) begin
        fails++;
        $display("FAIL two_word_data[%0d]: got %h@%h required %h@%h",
                 k, wr_d[k], wr_a[k], model_word(k), 32'(4 * k));
      end
    end
    tests_run++;
    if (wr_d.size() > 1 && wr_d[1] !== 32'h8877_6655) begin
      fails++;
      $display("FAIL two_word_literal: got %h required 88776655", wr_d[1]);
    end
  endtask

  task automatic test_back_pressure();
    int dc;
    int n;
    for (int pass = 0; pass < 3; pass++) begin
      n = (pass == 0) ? 3 : $urandom_range(1, 6);
      fill_stim(4 * n);
      clear_log();
      do_load(n, (pass == 0) ? 1 : 2, dc);
      tests_run++;
      if (dc < 0 || done_cnt !== 1 || ready_viol !== 0) begin
        fails++;
        $display("FAIL bp_flow[%0d]: done_cycle=%0d dones=%0d ready_in_write=%0d required >=0 1 0",
                 pass, dc, done_cnt, ready_viol);
      end
      tests_run++;
      if (wr_a.size() !== n) begin
        fails++;
        $display("FAIL bp_count[%0d]: writes=%0d required %0d", pass, wr_a.size(), n);
      end
      for (int k = 0; k < n && k < wr_a.size(); k++) begin
        tests_run++;
        if (wr_a[k] !== 32'(4 * k) || wr_d[k] !== model_word(k)) begin
          fails++;
          $display("FAIL bp_data[%0d.%0d]: got %h@%h required %h@%h",
                   pass, k, wr_d[k], wr_a[k], model_word(k), 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_rejected_start();
    int bad[2] = '{0, 103};
    foreach (bad[i]) begin
      clear_log();
      @(negedge clk);
      start     = 1'b1;
      num_words = 8'(bad[i]);
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if ({err, busy, byte_ready} !== 3'b100) begin
        fails++;
        $display("FAIL reject_%0d_pulse: err/busy/ready=%b required 100", bad[i], {err, busy, byte_ready});
      end
      @(negedge clk);
      tests_run++;
      if ({err, busy} !== 2'b00 || wr_a.size() !== 0 || done_cnt !== 0) begin
        fails++;
        $display("FAIL reject_%0d_after: err/busy=%b writes=%0d dones=%0d required 00 0 0",
                 bad[i], {err, busy}, wr_a.size(), done_cnt);
      end
    end
  endtask

  task automatic test_abort();
    int idx;
    int dc;
    // Abort in COLLECT after 2 bytes of word 1 of a 3-word load.
    fill_stim(12);
    clear_log();
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'd3;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int g = 0; g < 100 && idx < 6; g++) begin
      byte_valid = 1'b1;
      byte_in    = stim[idx];
      if (byte_ready) idx++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    abort      = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({busy, byte_ready, done, err} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_collect_idle: busy/ready/done/err=%b required 0000",
               {busy, byte_ready, done, err});
    end
    tests_run++;
    if (wr_a.size() !== 1 || done_cnt !== 0) begin
      fails++;
      $display("FAIL abort_collect_counts: writes=%0d dones=%0d required 1 0", wr_a.size(), done_cnt);
    end else if (wr_a[0] !== 32'h0 || wr_d[0] !== model_word(0)) begin
      fails++;
      $display("FAIL abort_collect_word0: got %h@%h required %h@00000000", wr_d[0], wr_a[0], model_word(0));
    end
    // Abort landing on the WRITE cycle of word 0 suppresses that write.
    fill_stim(8);
    clear_log();
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'd2;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int g = 0; g < 100 && idx < 4; g++) begin
      byte_valid = 1'b1;
      byte_in    = stim[idx];
      if (byte_ready) idx++;
      if (idx < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    abort      = 1'b1;
    #1;
    tests_run++;
    if (ram_we !== 1'b0) begin
      fails++;
      $display("FAIL abort_write_we: got %b required 0", ram_we);
    end
    @(negedge clk);
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || wr_a.size() !== 0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL abort_write_after: busy=%b writes=%0d dones=%0d required 0 0 0",
               busy, wr_a.size(), done_cnt);
    end
    // A fresh start after abort runs normally.
    fill_stim(4);
    clear_log();
    do_load(1, 0, dc);
    tests_run++;
    if (dc !== 6 || wr_a.size() !== 1) begin
      fails++;
      $display("FAIL abort_restart: done_cycle=%0d writes=%0d required 6 1", dc, wr_a.size());
    end else if (wr_a[0] !== 32'h0 || wr_d[0] !== model_word(0)) begin
      fails++;
      $display("FAIL abort_restart_data: got %h@%h required %h@00000000", wr_d[0], wr_a[0], model_word(0));
    end
  endtask

  task automatic test_reset_mid_load();
    int idx;
    int dc;
    fill_stim(8);
    clear_log();
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'd2;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int g = 0; g < 100 && idx < 3; g++) begin
      byte_valid = 1'b1;
      byte_in    = stim[idx];
      if (byte_ready) idx++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    cpu_we     = 1'b1;
    cpu_a      = 32'h10;
    cpu_wd     = $urandom;
    #1;
    tests_run++;
    if ({busy, ram_we} !== 2'b10) begin
      fails++;
      $display("FAIL cpu_during_busy: busy/we=%b required 10", {busy, ram_we});
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, byte_ready, done, err, ram_we} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset_outputs: busy/ready/done/err/we=%b required 00000",
               {busy, byte_ready, done, err, ram_we});
    end
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (wr_a.size() !== 0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL reset_no_write: writes=%0d dones=%0d required 0 0", wr_a.size(), done_cnt);
    end
    // A load after reset must not carry over the partial word.
    fill_stim(8);
    clear_log();
    do_load(2, 2, dc);
    tests_run++;
    if (dc < 0 || wr_a.size() !== 2) begin
      fails++;
      $display("FAIL reset_reload: done_cycle=%0d writes=%0d required >=0 2", dc, wr_a.size());
    end
    for (int k = 0; k < 2 && k < wr_a.size(); k++) begin
      tests_run++;
      if (wr_a[k] !== 32'(4 * k) || wr_d[k] !== model_word(k)) begin
        fails++;
        $display("FAIL reset_reload_data[%0d]: got %h@%h required %h@%h",
                 k, wr_d[k], wr_a[k], model_word(k), 32'(4 * k));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_words  = 8'd0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    cpu_we     = 1'b0;
    cpu_a      = 32'd0;
    cpu_wd     = 32'd0;
    done_cnt   = 0;
    ready_viol = 0;
    test_reset();
    test_two_word();
    test_back_pressure();
    test_rejected_start();
    test_abort();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
